cell_painter: RTL
=================

// Module: cell_painter
// PURPOSE
//  Inverse of the pixel->cell mapping. Takes one cell (line, column, colour) per
//  request, walks every pixel of that cell and emits a stream of framebuffer
//  writes (x, y, colour). Sits between the ant update logic and the VGA framebuffer
//  write port, and repaints a cell after the ant flips it.
// PARAMETERS
//  C_CELL_WIDTH      5  pixels per cell, horizontal (W)
//  C_CELL_HEIGHT     5  pixels per cell, vertical (H)
//  C_NUM_OF_CELLS_X  5  cells per row (X)
//  C_NUM_OF_CELLS_Y  5  cells per column (Y)
//  C_COLOR_BITS      1  colour word width
//  Elaboration check: X*W <= 1024 and Y*H <= 1024 (10-bit pixel space). Violation is a fatal error.
// PORTS
//  iclk        in   1                  clock
//  irst        in   1                  reset; synchronous, active-high
//  ireq_valid  in   1                  cell request valid
//  oreq_ready  out  1                  block idle, request accepted when valid&&ready
//  iline       in   CW                 cell row; CW = $clog2((X+Y)/2), same as the pixel->cell block
//  icolumn     in   CW                 cell column
//  icolor      in   C_COLOR_BITS       colour for the whole cell
//  opix_valid  out  1                  pixel write valid
//  ipix_ready  in   1                  framebuffer accepts pixel
//  opix_x      out  10                 pixel x = column*W + rx
//  opix_y      out  10                 pixel y = line*H + ry
//  opix_color  out  C_COLOR_BITS       latched icolor
//  olast       out  1                  marks the final pixel of the cell (rx=W-1, ry=H-1)
//  oerr        out  1                  one-cycle pulse: request out of range and dropped
// BEHAVIOUR
//  States: IDLE, PAINT. Every output is registered.
//  Reset (irst=1 at a clock edge): state=IDLE. All outputs are 0, including oreq_ready.
//   oreq_ready goes to 1 on the first edge after irst is released.
//  IDLE: oreq_ready=1, opix_valid=0.
//   Accept: ireq_valid&&oreq_ready at edge N.
//    - If iline>=Y or icolumn>=X: oerr=1 for cycle N+1 only, stay in IDLE, nothing is emitted.
//    - Otherwise: latch colour; base_x=column*W, base_y=line*H (constant multiply, 10-bit);
//      rx=ry=0; go to PAINT. oreq_ready=0 from N+1.
//  PAINT: opix_valid=1 starting at cycle N+1 (1-cycle latency).
//   Transfer = opix_valid && ipix_ready at an edge.
//   While opix_valid&&!ipix_ready: x, y, colour and olast stay stable.
//   On each transfer: rx++. When rx==W-1: rx=0, ry++.
//   Scan order is raster within the cell: x fastest.
//   The transfer with olast=1 moves the state to IDLE. At the next cycle opix_valid=0 and oreq_ready=1.
//  Throughput: W*H transfers plus 1 idle cycle per cell. There is no request overlap; back-to-back requests are stalled via oreq_ready.
//  Request inputs are ignored in PAINT (oreq_ready=0).
//  Degenerate W=1 or H=1: counters saturate correctly. For W=H=1, olast=1 on the single pixel.
//  Reset mid-PAINT: the cell is abandoned. opix_valid=0 from the next cycle and no partial resume.
//  oerr and a valid accept are mutually exclusive. oerr never asserts in PAINT.
// STRUCTURE
//  Shared package cell_geom_pkg holds:
//   - the cell-index width function CW(X,Y)
//   - the pixel coordinate width (10)
//   - the state enum {IDLE, PAINT}
//   The pixel->cell block takes its widths from the same package.
//  One sub-module, cell_offset_counter:
//   - 2-D rx/ry counter with enable and clear
//   - outputs rx, ry and wrap/last flags
//  The top module holds the FSM, the base registers and the output adders.
// TESTING (defaults W=H=X=Y=5, C_COLOR_BITS=1)
//  1 Hold irst for 3 cycles -> every output is 0 during reset. oreq_ready=1 on the 1st cycle after release.
//  2 Request line=2, col=3, color=1, ipix_ready=1 -> 25 pixels.
//    First pixel is (15,10), last is (19,14) with olast=1. oreq_ready returns 26 cycles after accept.
//  3 Same request, ipix_ready toggling 1/0 -> same 25-pixel sequence, with outputs stable on every stall cycle.
//  4 Request line=5, col=0 -> oerr=1 for exactly 1 cycle, opix_valid never rises, oreq_ready stays 1.
//  5 Assert irst after the 7th transfer -> opix_valid=0 next cycle. A new request line=0, col=0 starts at (0,0).
//  6 ireq_valid held high with two requests (4,4) then (0,1) -> first cell ends at (24,24).
//    Second cell starts at (5,0) exactly 2 cycles after the olast transfer.

Source files
------------

// File: rtl/cell_geom_pkg.sv
// Shared cell/pixel geometry: index widths, pixel coordinate width and painter states.
// The pixel->cell block draws its widths from here as well, so both directions agree.
package cell_geom_pkg;

    localparam int PIX_W   = 10;
    localparam int PIX_MAX = 1 << PIX_W;

    typedef enum logic {
        IDLE,
        PAINT
    } paint_state_t;

    // Cell index width, shared with the pixel->cell mapper; never narrower than one bit.
    function automatic int cell_idx_width(input int x, input int y);
        int w;
        w = $clog2((x + y) / 2);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cell_offset_counter.sv
// 2-D offset counter walking a W x H cell in raster order (x fastest).
// Flags are registered; next_last looks one step ahead so the caller can register its own last flag.
module cell_offset_counter
    import cell_geom_pkg::*;
#(
    parameter int W = 5,
    parameter int H = 5,
    localparam int RXW = cnt_width(W),
    localparam int RYW = cnt_width(H)
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           clear,
    input  logic           en,
    output logic [RXW-1:0] rx,
    output logic [RYW-1:0] ry,
    output logic           x_wrap,
    output logic           last,
    output logic           next_last
);

    logic [RXW-1:0] rx_next;
    logic [RYW-1:0] ry_next;

    always_comb begin
        rx_next = rx;
        ry_next = ry;
        if (x_wrap) begin
            rx_next = '0;
            ry_next = (ry == RYW'(H - 1)) ? '0 : ry + RYW'(1);
        end else begin
            rx_next = rx + RXW'(1);
        end
    end

    assign next_last = (rx_next == RXW'(W - 1)) && (ry_next == RYW'(H - 1));

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            rx     <= '0;
            ry     <= '0;
            x_wrap <= (W == 1);
            last   <= (W == 1 && H == 1);
        end else if (en) begin
            rx     <= rx_next;
            ry     <= ry_next;
            x_wrap <= (rx_next == RXW'(W - 1));
            last   <= next_last;
        end
    end

endmodule

// File: rtl/cell_painter.sv
// Expands one cell request into a raster stream of framebuffer pixel writes.
// Out-of-range requests are dropped with a one-cycle oerr pulse.
module cell_painter
    import cell_geom_pkg::*;
#(
    parameter int C_CELL_WIDTH     = 5,
    parameter int C_CELL_HEIGHT    = 5,
    parameter int C_NUM_OF_CELLS_X = 5,
    parameter int C_NUM_OF_CELLS_Y = 5,
    parameter int C_COLOR_BITS     = 1,
    localparam int CW = cell_idx_width(C_NUM_OF_CELLS_X, C_NUM_OF_CELLS_Y)
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    ireq_valid,
    output logic                    oreq_ready,
    input  logic [CW-1:0]           iline,
    input  logic [CW-1:0]           icolumn,
    input  logic [C_COLOR_BITS-1:0] icolor,
    output logic                    opix_valid,
    input  logic                    ipix_ready,
    output logic [PIX_W-1:0]        opix_x,
    output logic [PIX_W-1:0]        opix_y,
    output logic [C_COLOR_BITS-1:0] opix_color,
    output logic                    olast,
    output logic                    oerr
);

    localparam int RXW = cnt_width(C_CELL_WIDTH);
    localparam int RYW = cnt_width(C_CELL_HEIGHT);

    if (C_NUM_OF_CELLS_X * C_CELL_WIDTH > PIX_MAX ||
        C_NUM_OF_CELLS_Y * C_CELL_HEIGHT > PIX_MAX) begin : g_geom_check
        $fatal(1, "cell_painter: cell grid does not fit the 10-bit pixel space");
    end

    paint_state_t     state_reg;
    logic [PIX_W-1:0] base_x_reg;
    logic [PIX_W-1:0] base_y_reg;
    logic [RXW-1:0]   rx;
    logic [RYW-1:0]   ry;
    logic             x_wrap;
    logic             cell_last;
    logic             next_last;
    logic             req_accept;
    logic             req_bad;
    logic             cnt_clear;
    logic             pix_xfer;

    assign req_accept = (state_reg == IDLE) && ireq_valid && oreq_ready;
    assign req_bad    = (int'(iline) >= C_NUM_OF_CELLS_Y) || (int'(icolumn) >= C_NUM_OF_CELLS_X);
    assign cnt_clear  = req_accept && !req_bad;
    assign pix_xfer   = (state_reg == PAINT) && opix_valid && ipix_ready;

    cell_offset_counter #(
        .W (C_CELL_WIDTH),
        .H (C_CELL_HEIGHT)
    ) u_offset (
        .clk       (iclk),
        .srst      (irst),
        .clear     (cnt_clear),
        .en        (pix_xfer),
        .rx        (rx),
        .ry        (ry),
        .x_wrap    (x_wrap),
        .last      (cell_last),
        .next_last (next_last)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_reg  <= IDLE;
            base_x_reg <= '0;
            base_y_reg <= '0;
            oreq_ready <= 1'b0;
            opix_valid <= 1'b0;
            opix_x     <= '0;
            opix_y     <= '0;
            opix_color <= '0;
            olast      <= 1'b0;
            oerr       <= 1'b0;
        end else begin
            oerr <= 1'b0;
            case (state_reg)
                IDLE: begin
                    oreq_ready <= 1'b1;
                    opix_valid <= 1'b0;
                    olast      <= 1'b0;
                    if (req_accept) begin
                        if (req_bad) begin
                            oerr <= 1'b1;
                        end else begin
                            base_x_reg <= PIX_W'(icolumn) * PIX_W'(C_CELL_WIDTH);
                            base_y_reg <= PIX_W'(iline) * PIX_W'(C_CELL_HEIGHT);
                            opix_x     <= PIX_W'(icolumn) * PIX_W'(C_CELL_WIDTH);
                            opix_y     <= PIX_W'(iline) * PIX_W'(C_CELL_HEIGHT);
                            opix_color <= icolor;
                            olast      <= (C_CELL_WIDTH == 1 && C_CELL_HEIGHT == 1);
                            opix_valid <= 1'b1;
                            oreq_ready <= 1'b0;
                            state_reg  <= PAINT;
                        end
                    end
                end
                PAINT: begin
                    if (pix_xfer) begin
                        if (cell_last) begin
                            state_reg  <= IDLE;
                            opix_valid <= 1'b0;
                            olast      <= 1'b0;
                            oreq_ready <= 1'b1;
                        end else begin
                            // Coordinates follow the counter's next position; stalls leave them untouched.
                            opix_x <= x_wrap ? base_x_reg : base_x_reg + PIX_W'(rx) + PIX_W'(1);
                            opix_y <= x_wrap ? base_y_reg + PIX_W'(ry) + PIX_W'(1) : opix_y;
                            olast  <= next_last;
                        end
                    end
                end
            endcase
        end
    end

endmodule
